// File: rtl/lc4_div_mod_unit.sv
`default_nettype none
// ============================================================================
// Module   : lc4_div_mod_unit
// Purpose  : Multicycle DIV/MOD execute stage placed around the combinational
//            lc4_divider. It accepts one request per valid/ready handshake and
//            latches the operands. The operands stay stable on the divider
//            inputs for LATENCY cycles, because the divider is a declared
//            multicycle path. The unit then captures the quotient or the
//            remainder and presents it to writeback with a destination tag.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   LATENCY  cycles the operands are held before the divider is sampled (>= 1)
//   TAG_W    destination register tag width
// Ports
//   clk, rst_n                       clock (rising edge), async active-low reset
//   i_flush                          synchronous squash of any in-flight op
//   i_req_valid / o_req_ready        request handshake
//   i_op, i_dividend, i_divisor,     request payload (op 0 = DIV, 1 = MOD)
//   i_rd
//   o_div_dividend / o_div_divisor   registered operands to the divider
//   i_div_quotient / i_div_remainder divider results
//   o_rsp_valid / i_rsp_ready        response handshake
//   o_result, o_rd, o_div_by_zero    response payload
// ============================================================================
module lc4_div_mod_unit #(
  parameter int LATENCY = 2,
  parameter int TAG_W   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic             i_op,
  input  logic [15:0]      i_dividend,
  input  logic [15:0]      i_divisor,
  input  logic [TAG_W-1:0] i_rd,
  output logic [15:0]      o_div_dividend,
  output logic [15:0]      o_div_divisor,
  input  logic [15:0]      i_div_quotient,
  input  logic [15:0]      i_div_remainder,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [15:0]      o_result,
  output logic [TAG_W-1:0] o_rd,
  output logic             o_div_by_zero
);

  // The counter must be able to hold LATENCY-1. It must also be at least one
  // bit wide, so that LATENCY == 1 still synthesizes.
  localparam int              CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [15:0]        dividend_held;
  logic [15:0]        divisor_held;
  logic               op_held;
  logic               zero_held;
  logic [TAG_W-1:0]   rd_held;
  logic               rsp_valid;
  logic [15:0]        result;
  logic [TAG_W-1:0]   rd_out;
  logic               dbz;

  logic               accept;
  logic [15:0]        captured;

  // The unit is ready when it is idle. It is also ready when the pending
  // result drains on this same edge, which allows back-to-back operation.
  assign o_req_ready = (state == ST_IDLE) | ((state == ST_DONE) & i_rsp_ready);
  assign accept      = i_req_valid & o_req_ready & ~i_flush;

  // A divide-by-zero request also passes through BUSY, but with a zero count.
  // The divider output is ignored in that case, and the result is forced to 0.
  assign captured = zero_held ? 16'h0000
                              : (op_held ? i_div_remainder : i_div_quotient);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      dividend_held <= '0;
      divisor_held  <= '0;
      op_held       <= 1'b0;
      zero_held     <= 1'b0;
      rd_held       <= '0;
      rsp_valid     <= 1'b0;
      result        <= '0;
      rd_out        <= '0;
      dbz           <= 1'b0;
    end else if (i_flush) begin
      // A squash takes priority over both drain and accept. The operand
      // registers keep their values, so the divider inputs do not toggle.
      state     <= ST_IDLE;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_IDLE;
        end
        ST_BUSY: begin
          if (cnt == '0) begin
            result    <= captured;
            dbz       <= zero_held;
            rd_out    <= rd_held;
            rsp_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ST_DONE: begin
          if (i_rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
        end
      endcase

      // An accept can only happen in IDLE or on a draining DONE. In either
      // case it overrides the state update made above.
      if (accept) begin
        dividend_held <= i_dividend;
        divisor_held  <= i_divisor;
        op_held       <= i_op;
        rd_held       <= i_rd;
        zero_held     <= (i_divisor == 16'h0000);
        cnt           <= (i_divisor == 16'h0000) ? '0 : CNT_INIT;
        state         <= ST_BUSY;
      end
    end
  end

  assign o_div_dividend = dividend_held;
  assign o_div_divisor  = divisor_held;
  assign o_rsp_valid    = rsp_valid;
  assign o_result       = result;
  assign o_rd           = rd_out;
  assign o_div_by_zero  = dbz;

endmodule
`default_nettype wire

// File: tb/tb_lc4_div_mod_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc4_div_mod_unit
// Purpose  : Directed and randomized self-checking bench for lc4_div_mod_unit.
//            The bench models the external divider behaviourally, and it
//            predicts every response with plain arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lc4_div_mod_unit;

  localparam int LAT = 2;
  localparam int TW  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          op = 1'b0;
  logic [15:0]   dividend = '0;
  logic [15:0]   divisor = '0;
  logic [TW-1:0] rd = '0;
  logic [15:0]   div_dividend;
  logic [15:0]   div_divisor;
  logic [15:0]   div_quotient;
  logic [15:0]   div_remainder;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [15:0]   result;
  logic [TW-1:0] rd_out;
  logic          dbz;

  int n_cmp = 0;
  int n_err = 0;

  lc4_div_mod_unit #(.LATENCY(LAT), .TAG_W(TW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_flush         (flush),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_op            (op),
    .i_dividend      (dividend),
    .i_divisor       (divisor),
    .i_rd            (rd),
    .o_div_dividend  (div_dividend),
    .o_div_divisor   (div_divisor),
    .i_div_quotient  (div_quotient),
    .i_div_remainder (div_remainder),
    .o_rsp_valid     (rsp_valid),
    .i_rsp_ready     (rsp_ready),
    .o_result        (result),
    .o_rd            (rd_out),
    .o_div_by_zero   (dbz)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the combinational lc4_divider. For a zero
  // divisor it returns a deliberately nonzero pattern.
  always_comb begin
    div_quotient  = 16'hFFFF;
    div_remainder = div_dividend;
    if (div_divisor != 16'h0000) begin
      div_quotient  = div_dividend / div_divisor;
      div_remainder = div_dividend % div_divisor;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request, confirms the unit is ready, and takes the accept edge.
  task automatic issue(input logic o, input logic [15:0] a, input logic [15:0] b,
                       input logic [TW-1:0] r);
    op = o; dividend = a; divisor = b; rd = r; req_valid = 1'b1;
    #1;
    chk("issue_ready", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until the response appears, and checks
  // the payload against plain arithmetic.
  task automatic wait_rsp(input string tag, input logic o, input logic [15:0] a,
                          input logic [15:0] b, input logic [TW-1:0] r);
    int          lat;
    logic [15:0] exp_res;
    int          exp_lat;
    lat     = 0;
    exp_res = (b == 16'h0) ? 16'h0 : (o ? (a % b) : (a / b));
    exp_lat = (b == 16'h0) ? 1 : LAT;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      chk({tag, "_hold_a"}, {16'd0, div_dividend}, {16'd0, a});
      chk({tag, "_hold_b"}, {16'd0, div_divisor}, {16'd0, b});
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_result"}, {16'd0, result}, {16'd0, exp_res});
    chk({tag, "_rd"}, {29'd0, rd_out}, {29'd0, r});
    chk({tag, "_dbz"}, {31'd0, dbz}, {31'd0, (b == 16'h0)});
  endtask

  task automatic drain(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_drained"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    logic          ro;
    logic [15:0]   ra;
    logic [15:0]   rb;
    logic [TW-1:0] rr;
    int            hold;

    // Reset state
    #1;
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_dbz", {31'd0, dbz}, 32'd0);
    chk("rst_operand", {16'd0, div_dividend}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic DIV / MOD
    issue(1'b0, 16'd100, 16'd7, 3'd3);
    wait_rsp("div100_7", 1'b0, 16'd100, 16'd7, 3'd3);
    drain("div100_7");
    issue(1'b1, 16'd100, 16'd7, 3'd1);
    wait_rsp("mod100_7", 1'b1, 16'd100, 16'd7, 3'd1);
    drain("mod100_7");
    issue(1'b1, 16'hFFFF, 16'd1, 3'd2);
    wait_rsp("modffff_1", 1'b1, 16'hFFFF, 16'd1, 3'd2);
    drain("modffff_1");
    issue(1'b0, 16'hFFFF, 16'd1, 3'd7);
    wait_rsp("divffff_1", 1'b0, 16'hFFFF, 16'd1, 3'd7);
    drain("divffff_1");

    // Divide by zero, then a normal op clears the flag
    issue(1'b0, 16'd5, 16'd0, 3'd4);
    wait_rsp("div5_0", 1'b0, 16'd5, 16'd0, 3'd4);
    drain("div5_0");
    issue(1'b0, 16'd9, 16'd3, 3'd4);
    wait_rsp("div9_3", 1'b0, 16'd9, 16'd3, 3'd4);
    drain("div9_3");

    // Backpressure in DONE, then same-cycle drain and accept
    issue(1'b0, 16'd1000, 16'd10, 3'd5);
    wait_rsp("bp_first", 1'b0, 16'd1000, 16'd10, 3'd5);
    op = 1'b1; dividend = 16'd1000; divisor = 16'd7; rd = 3'd6; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_result", {16'd0, result}, 32'd100);
      chk("bp_rd", {29'd0, rd_out}, 32'd5);
      chk("bp_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_no_accept", {16'd0, div_divisor}, 32'd10);
    end
    rsp_ready = 1'b1;
    #1;
    chk("b2b_ready", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("b2b_valid_drop", {31'd0, rsp_valid}, 32'd0);
    wait_rsp("b2b_second", 1'b1, 16'd1000, 16'd7, 3'd6);
    drain("b2b_second");

    // Flush in BUSY with cnt=1
    issue(1'b0, 16'd200, 16'd9, 3'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy_valid", {31'd0, rsp_valid}, 32'd0);
    chk("flush_busy_ready", {31'd0, req_ready}, 32'd1);
    tick();
    tick();
    chk("flush_busy_valid2", {31'd0, rsp_valid}, 32'd0);

    // Flush in DONE beats the drain and a new accept
    issue(1'b1, 16'd200, 16'd9, 3'd2);
    wait_rsp("pre_flush", 1'b1, 16'd200, 16'd9, 3'd2);
    flush = 1'b1; rsp_ready = 1'b1;
    op = 1'b0; dividend = 16'd77; divisor = 16'd7; rd = 3'd3; req_valid = 1'b1;
    tick();
    flush = 1'b0; rsp_ready = 1'b0; req_valid = 1'b0;
    chk("flush_done_valid", {31'd0, rsp_valid}, 32'd0);
    chk("flush_done_no_accept", {16'd0, div_dividend}, 32'd200);
    tick();
    chk("flush_done_valid2", {31'd0, rsp_valid}, 32'd0);

    // Asynchronous reset mid-BUSY
    issue(1'b0, 16'd100, 16'd7, 3'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("arst_ready", {31'd0, req_ready}, 32'd1);
    chk("arst_operand", {16'd0, div_dividend}, 32'd0);
    rst_n = 1'b1;
    #1;
    issue(1'b0, 16'd40, 16'd6, 3'd2);
    wait_rsp("div40_6", 1'b0, 16'd40, 16'd6, 3'd2);
    drain("div40_6");

    // Randomized operations against the arithmetic model
    for (int n = 0; n < 40; n++) begin
      ro = 1'($urandom_range(0, 1));
      ra = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 16'd0;
        1, 2:    rb = 16'($urandom_range(1, 20));
        default: rb = 16'($urandom);
      endcase
      rr = TW'($urandom_range(0, 7));
      issue(ro, ra, rb, rr);
      wait_rsp("rand", ro, ra, rb, rr);
      hold = int'($urandom_range(0, 3));
      for (int h = 0; h < hold; h++) begin
        tick();
        chk("rand_hold_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rand_hold_rd", {29'd0, rd_out}, {29'd0, rr});
      end
      drain("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
